tile_sequencer: RTL and testbench
=================================

TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 Parameter WIDTH_HEIGHT, default 16, systolic array edge and rows per tile.
REQ-002 Parameter MAX_MAT_WH, default 128, maximum matrix edge; TW = $clog2(MAX_MAT_WH/WIDTH_HEIGHT) (3 at defaults).
REQ-003 Parameter ADDR_WIDTH, default 8, memory row address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req_valid  in  1  job request.
REQ-007 req_ready  out  1  high only in IDLE.
REQ-008 tiles_m, tiles_k, tiles_n  in  TW each  tile counts minus one.
REQ-009 in_base, w_base, out_base  in  ADDR_WIDTH each  base rows of the input, weight and output memories.
REQ-010 relu_req  in  1  apply ReLU on store.
REQ-011 abort  in  1  cancel the job.
REQ-012 core_start  out  1  one-cycle command pulse to the core.
REQ-013 core_opcode  out  3  command opcode.
REQ-014 core_addr  out  ADDR_WIDTH  command base row.
REQ-015 core_submat_row, core_submat_col  out  TW each  accumulator tile indices (m, n).
REQ-016 core_done  in  1  core command-complete pulse.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 job_done  out  1  one-cycle pulse when the job finishes.

Function
REQ-019 States: IDLE, CLEAR, LOAD_W, COMPUTE, STORE, ADVANCE, FINISH; each command state has ISSUE and WAIT phases.
REQ-020 A request is accepted when req_valid && req_ready; accepting it latches all request inputs and zeroes counters m, k, n.
REQ-021 ISSUE lasts one cycle with core_start=1; WAIT holds core_start=0 until core_done.
REQ-022 core_opcode, core_addr and core_submat_* are registered and stable from ISSUE through the core_done cycle.
REQ-023 Opcodes: CLEAR=3'd1, LOAD_W=3'd2, COMPUTE=3'd3, STORE=3'd4, STORE_RELU=3'd5; IDLE drives 3'd0.
REQ-024 Sequence per output tile (m,n): CLEAR, then for k=0..tiles_k the pair LOAD_W then COMPUTE, then STORE, or STORE_RELU if relu_req was latched.
REQ-025 Addresses:
- LOAD_W = w_base + (k*(tiles_n+1)+n)*WIDTH_HEIGHT.
- COMPUTE = in_base + (m*(tiles_k+1)+k)*WIDTH_HEIGHT.
- STORE = out_base + (m*(tiles_n+1)+n)*WIDTH_HEIGHT.
- All sums are truncated modulo 2^ADDR_WIDTH (wrap-around, no error).
REQ-026 ADVANCE lasts one cycle: n increments; at tiles_n, n wraps to 0 and m increments; at m==tiles_m and n==tiles_n, go to FINISH.
REQ-027 FINISH pulses job_done for one cycle, then returns to IDLE; the next request can be accepted on the following cycle.
REQ-028 core_done is ignored outside WAIT and in the ISSUE cycle itself.
REQ-029 abort (not in IDLE) forces IDLE on the next edge: no job_done, no further core_start; the outstanding core_done is ignored.
REQ-030 Command count per job = (tiles_m+1)(tiles_n+1)(2(tiles_k+1)+2).

Reset
REQ-031 reset forces IDLE from any state, including mid-command.
REQ-032 Output values in reset: core_start=0, core_opcode=0, core_addr=0, core_submat_*=0, busy=0, job_done=0, req_ready=1 on the first cycle after reset.

Structure
REQ-033 A shared package holds the opcode constants, the state enum and the TW width function, for reuse by the core control.
REQ-034 One sub-module, tile_addr_gen: combinational multiply-add address generation, instantiated once and muxed by state.

Verification
REQ-035 1x1x1 job (all tiles_*=0, bases 0, relu_req=0), core_done 3 cycles after each start -> opcodes 1,2,3,4 at addrs 0,0,0,0; one job_done.
REQ-036 tiles_m=1, tiles_k=1, tiles_n=1, w_base=8'h40 -> 24 starts; second LOAD_W of tile (0,0) at addr 0x60; STORE of tile (1,1) at out_base+0x30; submat_row/col follow (0,0),(0,1),(1,0),(1,1).
REQ-037 in_base=8'hF0, tiles_m=1, tiles_k=0 -> COMPUTE for m=1 at addr 8'h00 (wrap).
REQ-038 relu_req=1 -> every store opcode is 3'd5.
REQ-039 Timing corner cases:
- core_done during ISSUE is ignored.
- A spurious core_done in IDLE is ignored.
- abort in WAIT of a COMPUTE -> IDLE next cycle, no job_done, req_ready=1.
REQ-040 reset asserted mid-LOAD_W -> all outputs at reset values next cycle; a new job then runs from m=n=k=0.

Source files
------------

// File: rtl/tile_sequencer_pkg.sv
// Shared types for the tile sequencer and the core control: opcodes, state enum, tile-index width.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tile_sequencer_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_CLEAR      = 3'd1;
  localparam logic [2:0] OP_LOAD_W     = 3'd2;
  localparam logic [2:0] OP_COMPUTE    = 3'd3;
  localparam logic [2:0] OP_STORE      = 3'd4;
  localparam logic [2:0] OP_STORE_RELU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_W,
    COMPUTE,
    STORE,
    ADVANCE,
    FINISH
  } state_e;

  // Bits needed to index tiles along one matrix edge; never narrower than one bit.
  function automatic int tile_idx_width(input int max_mat_wh, input int width_height);
    int w;
    w = $clog2(max_mat_wh / width_height);
    return (w < 1) ? 1 : w;
  endfunction

  // States that issue a command to the core (each has ISSUE and WAIT phases).
  function automatic logic is_cmd_state(input state_e s);
    return (s inside {CLEAR, LOAD_W, COMPUTE, STORE});
  endfunction

  function automatic logic [2:0] state_opcode(input state_e s, input logic relu);
    case (s)
      CLEAR:   return OP_CLEAR;
      LOAD_W:  return OP_LOAD_W;
      COMPUTE: return OP_COMPUTE;
      STORE:   return relu ? OP_STORE_RELU : OP_STORE;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/tile_sequencer_if.sv
// Command bus between the tile sequencer (master) and the systolic core (slave).
// Latency: n/a (wires only).
// Backpressure: the core acknowledges each core_start with a later core_done pulse.
interface tile_sequencer_if #(
  parameter int TW         = 3,
  parameter int ADDR_WIDTH = 8
);
  logic                  core_start;
  logic [2:0]            core_opcode;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [TW-1:0]         core_submat_row;
  logic [TW-1:0]         core_submat_col;
  logic                  core_done;

  modport master (
    output core_start, core_opcode, core_addr, core_submat_row, core_submat_col,
    input  core_done
  );

  modport slave (
    input  core_start, core_opcode, core_addr, core_submat_row, core_submat_col,
    output core_done
  );
endinterface

// File: rtl/tile_addr_gen.sv
// Row address of a tile: base + (major*(stride_m1+1)+minor)*WIDTH_HEIGHT, modulo 2^ADDR_WIDTH.
// Latency: combinational.
// Backpressure: none.
module tile_addr_gen #(
  parameter int TW           = 3,
  parameter int ADDR_WIDTH   = 8,
  parameter int WIDTH_HEIGHT = 16
) (
  input  logic [TW-1:0]         major,
  input  logic [TW-1:0]         minor,
  input  logic [TW-1:0]         stride_m1,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] addr
);

  // Everything is computed at address width so wrap-around falls out of the arithmetic.
  always_comb begin
    addr = base + (ADDR_WIDTH'(major) * (ADDR_WIDTH'(stride_m1) + ADDR_WIDTH'(1))
                   + ADDR_WIDTH'(minor)) * ADDR_WIDTH'(WIDTH_HEIGHT);
  end

endmodule

// File: rtl/tile_sequencer.sv
// Walks a tiled matmul job, issuing CLEAR / LOAD_W / COMPUTE / STORE commands to the core.
// Latency: request accepted in IDLE; first core_start the cycle after acceptance.
// Backpressure: req_ready only in IDLE; each command waits for core_done; abort returns to IDLE.
module tile_sequencer
  import tile_sequencer_pkg::*;
#(
  parameter int  WIDTH_HEIGHT = 16,
  parameter int  MAX_MAT_WH   = 128,
  parameter int  ADDR_WIDTH   = 8,
  localparam int TW           = tile_idx_width(MAX_MAT_WH, WIDTH_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TW-1:0]         tiles_m,
  input  logic [TW-1:0]         tiles_k,
  input  logic [TW-1:0]         tiles_n,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic                  relu_req,
  input  logic                  abort,
  output logic                  busy,
  output logic                  job_done,
  tile_sequencer_if.master      core
);

  state_e                state_q, state_d;
  logic                  wait_q, wait_d;
  logic [TW-1:0]         m_q, m_d, k_q, k_d, n_q, n_d;
  logic [TW-1:0]         tm_q, tm_d, tk_q, tk_d, tn_q, tn_d;
  logic [ADDR_WIDTH-1:0] in_q, in_d, w_q, w_d, out_q, out_d;
  logic                  relu_q, relu_d;
  logic                  accept;

  logic [TW-1:0]         ag_major, ag_minor, ag_stride;
  logic [ADDR_WIDTH-1:0] ag_base, ag_addr;

  logic [2:0]            opcode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TW-1:0]         row_q, col_q;

  assign accept    = req_valid && (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign job_done  = (state_q == FINISH);

  assign core.core_start      = is_cmd_state(state_q) && !wait_q;
  assign core.core_opcode     = opcode_q;
  assign core.core_addr       = addr_q;
  assign core.core_submat_row = row_q;
  assign core.core_submat_col = col_q;

  // Job parameters: take the request inputs on acceptance, otherwise hold.
  always_comb begin
    tm_d   = tm_q;
    tk_d   = tk_q;
    tn_d   = tn_q;
    in_d   = in_q;
    w_d    = w_q;
    out_d  = out_q;
    relu_d = relu_q;
    if (accept) begin
      tm_d   = tiles_m;
      tk_d   = tiles_k;
      tn_d   = tiles_n;
      in_d   = in_base;
      w_d    = w_base;
      out_d  = out_base;
      relu_d = relu_req;
    end
  end

  // Next state, phase and tile counters; core_done only counts in the WAIT phase.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    m_d     = m_q;
    k_d     = k_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = CLEAR;
          wait_d  = 1'b0;
          m_d     = '0;
          k_d     = '0;
          n_d     = '0;
        end
      end
      CLEAR, LOAD_W, COMPUTE, STORE: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (core.core_done) begin
          wait_d = 1'b0;
          case (state_q)
            CLEAR:   state_d = LOAD_W;
            LOAD_W:  state_d = COMPUTE;
            COMPUTE: begin
              if (k_q == tk_q) begin
                state_d = STORE;
              end else begin
                k_d     = k_q + 1'b1;
                state_d = LOAD_W;
              end
            end
            default: state_d = ADVANCE;
          endcase
        end
      end
      ADVANCE: begin
        k_d     = '0;
        state_d = CLEAR;
        if (n_q == tn_q) begin
          n_d = '0;
          if (m_q == tm_q) begin
            state_d = FINISH;
          end else begin
            m_d = m_q + 1'b1;
          end
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      wait_d  = 1'b0;
    end
  end

  // Address operands for the command about to be issued; CLEAR targets the output tile.
  always_comb begin
    ag_major  = m_d;
    ag_minor  = n_d;
    ag_stride = tn_d;
    ag_base   = out_d;
    case (state_d)
      LOAD_W: begin
        ag_major  = k_d;
        ag_minor  = n_d;
        ag_stride = tn_d;
        ag_base   = w_d;
      end
      COMPUTE: begin
        ag_major  = m_d;
        ag_minor  = k_d;
        ag_stride = tk_d;
        ag_base   = in_d;
      end
      default: ;
    endcase
  end

  tile_addr_gen #(
    .TW           (TW),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .WIDTH_HEIGHT (WIDTH_HEIGHT)
  ) u_addr_gen (
    .major     (ag_major),
    .minor     (ag_minor),
    .stride_m1 (ag_stride),
    .base      (ag_base),
    .addr      (ag_addr)
  );

  // State, phase, counters and latched job parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      tm_q    <= '0;
      tk_q    <= '0;
      tn_q    <= '0;
      in_q    <= '0;
      w_q     <= '0;
      out_q   <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      m_q     <= m_d;
      k_q     <= k_d;
      n_q     <= n_d;
      tm_q    <= tm_d;
      tk_q    <= tk_d;
      tn_q    <= tn_d;
      in_q    <= in_d;
      w_q     <= w_d;
      out_q   <= out_d;
      relu_q  <= relu_d;
    end
  end

  // Command fields load on entry to ISSUE and hold through the core_done cycle; zero in IDLE.
  always_ff @(posedge clk) begin
    if (reset || (state_d == IDLE)) begin
      opcode_q <= OP_NOP;
      addr_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else if (is_cmd_state(state_d) && !wait_d) begin
      opcode_q <= state_opcode(state_d, relu_d);
      addr_q   <= ag_addr;
      row_q    <= m_d;
      col_q    <= n_d;
    end
  end

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with a command scoreboard and a delayed-done core model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tile_sequencer;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] addr;
    logic [2:0] row;
    logic [2:0] col;
  } cmd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] tiles_m, tiles_k, tiles_n;
  logic [7:0] in_base, w_base, out_base;
  logic       relu_req;
  logic       abort;
  logic       busy;
  logic       job_done;

  logic       auto_en;
  logic       auto_done;
  logic       man_done;
  int         resp_cnt;
  int         resp_dly;

  int         n_asserts;
  int         n_fail;
  int         start_cnt;
  int         jd_cnt;
  cmd_t       exp_q[$];
  cmd_t       obs_q[$];
  cmd_t       mon_obs;
  cmd_t       mon_exp;

  tile_sequencer_if #(.TW(3), .ADDR_WIDTH(8)) bus ();

  assign bus.core_done = auto_done | man_done;

  tile_sequencer #(
    .WIDTH_HEIGHT (16),
    .MAX_MAT_WH   (128),
    .ADDR_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .tiles_m   (tiles_m),
    .tiles_k   (tiles_k),
    .tiles_n   (tiles_n),
    .in_base   (in_base),
    .w_base    (w_base),
    .out_base  (out_base),
    .relu_req  (relu_req),
    .abort     (abort),
    .busy      (busy),
    .job_done  (job_done),
    .core      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Core model: answers each core_start with core_done resp_dly cycles later.
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (reset) begin
      resp_cnt = 0;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) auto_done = 1'b1;
    end
    if (!reset && auto_en && bus.core_start) resp_cnt = resp_dly;
  end

  // Monitor: every issued command is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (job_done) jd_cnt++;
      if (bus.core_start) begin
        start_cnt++;
        mon_obs = {bus.core_opcode, bus.core_addr, bus.core_submat_row, bus.core_submat_col};
        obs_q.push_back(mon_obs);
        check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("cmd", 32'(mon_obs), 32'(mon_exp));
        end
      end
    end
  end

  // Reference command stream for one job; returns the expected number of commands.
  function automatic int push_model(input int tm, input int tk, input int tn,
                                    input int ib, input int wb, input int ob, input bit relu);
    cmd_t c;
    int   cnt = 0;
    for (int m = 0; m <= tm; m++) begin
      for (int n = 0; n <= tn; n++) begin
        c.row  = 3'(m);
        c.col  = 3'(n);
        c.op   = 3'd1;
        c.addr = 8'((ob + (m * (tn + 1) + n) * 16) % 256);
        exp_q.push_back(c);
        cnt++;
        for (int k = 0; k <= tk; k++) begin
          c.op   = 3'd2;
          c.addr = 8'((wb + (k * (tn + 1) + n) * 16) % 256);
          exp_q.push_back(c);
          c.op   = 3'd3;
          c.addr = 8'((ib + (m * (tk + 1) + k) * 16) % 256);
          exp_q.push_back(c);
          cnt += 2;
        end
        c.op   = relu ? 3'd5 : 3'd4;
        c.addr = 8'((ob + (m * (tn + 1) + n) * 16) % 256);
        exp_q.push_back(c);
        cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic start_job(input int tm, input int tk, input int tn,
                           input int ib, input int wb, input int ob, input bit relu,
                           output int exp_starts);
    exp_starts = push_model(tm, tk, tn, ib, wb, ob, relu);
    check("starts_formula", 32'(exp_starts), 32'((tm + 1) * (tn + 1) * (2 * (tk + 1) + 2)));
    start_cnt = 0;
    jd_cnt    = 0;
    obs_q.delete();
    tiles_m   = 3'(tm);
    tiles_k   = 3'(tk);
    tiles_n   = 3'(tn);
    in_base   = 8'(ib);
    w_base    = 8'(wb);
    out_base  = 8'(ob);
    relu_req  = relu;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_job(input string tag, input int exp_starts);
    int cyc = 0;
    while (jd_cnt == 0 && cyc < 4000) begin
      step();
      cyc++;
    end
    step();
    check({tag, "_job_done"}, 32'(jd_cnt), 32'd1);
    check({tag, "_starts"}, 32'(start_cnt), 32'(exp_starts));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, {30'd0, busy, req_ready}, 32'b01);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(bus.core_start), 32'd0);
    check({tag, "_op_addr"}, {21'd0, bus.core_opcode, bus.core_addr}, 32'd0);
    check({tag, "_submat"}, {26'd0, bus.core_submat_row, bus.core_submat_col}, 32'd0);
    check({tag, "_busy_done_ready"}, {29'd0, busy, job_done, req_ready}, 32'b001);
  endtask

  initial begin
    int exp_starts;
    int cyc;
    int relu_stores;
    int starts_at_abort;
    n_asserts = 0;
    n_fail    = 0;
    start_cnt = 0;
    jd_cnt    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    tiles_m   = '0;
    tiles_k   = '0;
    tiles_n   = '0;
    in_base   = '0;
    w_base    = '0;
    out_base  = '0;
    relu_req  = 1'b0;
    abort     = 1'b0;
    auto_en   = 1'b1;
    man_done  = 1'b0;
    resp_dly  = 3;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_reset_outputs("post_reset");

    // 1x1x1 job: opcodes 1,2,3,4 at address 0.
    start_job(0, 0, 0, 0, 0, 0, 1'b0, exp_starts);
    wait_job("job111", exp_starts);

    // 2x2x2 tiles with w_base 0x40 and out_base 0x10.
    start_job(1, 1, 1, 0, 8'h40, 8'h10, 1'b0, exp_starts);
    wait_job("job222", exp_starts);
    check("second_loadw_addr", 32'(obs_q[3].addr), 32'h60);
    check("last_store_addr", 32'(obs_q[23].addr), 32'h40);

    // Input address wrap-around.
    start_job(1, 0, 0, 8'hF0, 0, 0, 1'b0, exp_starts);
    wait_job("wrap", exp_starts);
    check("wrap_compute_m1", {24'd0, obs_q[6].op, 5'd0} | 32'(obs_q[6].addr), {24'd0, 3'd3, 5'd0});

    // ReLU stores with a short core latency.
    resp_dly = 1;
    start_job(0, 1, 2, 8'h08, 8'h20, 8'h80, 1'b1, exp_starts);
    wait_job("relu", exp_starts);
    relu_stores = 0;
    foreach (obs_q[i]) if (obs_q[i].op == 3'd5) relu_stores++;
    check("relu_store_count", 32'(relu_stores), 32'd3);
    resp_dly = 3;

    // core_done during ISSUE must not complete the command.
    auto_en = 1'b0;
    start_job(0, 0, 0, 0, 0, 0, 1'b0, exp_starts);
    cyc = 0;
    while (!bus.core_start && cyc < 20) begin
      step();
      cyc++;
    end
    check("issue_seen", 32'(bus.core_start), 32'd1);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("issue_done_ignored", {29'd0, bus.core_start, busy, 1'b0} | 32'(bus.core_opcode) << 4,
          {29'd0, 1'b0, 1'b1, 1'b0} | 32'd1 << 4);
    step();
    step();
    check("still_waiting_clear", {28'd0, bus.core_opcode, bus.core_start}, {28'd0, 3'd1, 1'b0});
    auto_en  = 1'b1;
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    wait_job("issue_done", exp_starts);

    // Spurious core_done in IDLE.
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    step();
    check("idle_spurious_done", {28'd0, bus.core_start, busy, job_done, req_ready}, 32'b0001);
    check("idle_spurious_no_start", 32'(start_cnt), 32'(exp_starts));

    // Abort while waiting on a COMPUTE.
    start_job(0, 1, 0, 8'h10, 8'h20, 8'h30, 1'b0, exp_starts);
    cyc = 0;
    while (!(bus.core_opcode == 3'd3 && !bus.core_start) && cyc < 50) begin
      step();
      cyc++;
    end
    check("abort_in_compute_wait", 32'(bus.core_opcode), 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    starts_at_abort = start_cnt;
    check_reset_outputs("after_abort");
    repeat (8) step();
    check("abort_no_job_done", 32'(jd_cnt), 32'd0);
    check("abort_no_more_starts", 32'(start_cnt), 32'(starts_at_abort));
    check("abort_still_idle", {30'd0, busy, req_ready}, 32'b01);
    exp_q.delete();

    // Reset in the middle of a LOAD_W, then a clean job from tile (0,0).
    start_job(1, 1, 1, 0, 8'h40, 8'h10, 1'b0, exp_starts);
    cyc = 0;
    while (!(bus.core_opcode == 3'd2 && !bus.core_start) && cyc < 50) begin
      step();
      cyc++;
    end
    check("reset_in_loadw", 32'(bus.core_opcode), 32'd2);
    reset = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    step();
    start_job(1, 0, 1, 8'h04, 8'h08, 8'h0C, 1'b0, exp_starts);
    wait_job("after_reset", exp_starts);
    check("after_reset_first_tile", {26'd0, obs_q[0].row, obs_q[0].col}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
